// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state and access owner encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LDR  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester handshakes plus the shared memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requester/memory side.
  modport master (
    output c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module rr_pick2 import mem_arb_pkg::*; (
  input  logic [1:0] req,        // [0] core, [1] loader
  input  owner_t     last_owner,
  output owner_t     winner,
  output logic       any
);

  always_comb begin
    any = |req;
    if (req == 2'b11) begin
      winner = (last_owner == OWN_CORE) ? OWN_LDR : OWN_CORE;
    end else if (req[1]) begin
      winner = OWN_LDR;
    end else begin
      winner = OWN_CORE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core and the UART loader, sequencing each
// access through grant, issue and a fixed read-latency wait.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, last_owner_q, winner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              any, grant, rvalid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req        ({bus.l_req, bus.c_req}),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any        (any)
  );

  // Gating with reset keeps gnt low while reset is held, even with requests pending.
  assign grant = (state_q == IDLE) && any && !reset;

  always_comb begin
    sel_we    = (winner == OWN_LDR) ? bus.l_we    : bus.c_we;
    sel_addr  = (winner == OWN_LDR) ? bus.l_addr  : bus.c_addr;
    sel_wdata = (winner == OWN_LDR) ? bus.l_wdata : bus.c_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) state_d = ISSUE;
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = LAT_W'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - LAT_W'(1);
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_CORE;
      last_owner_q <= OWN_LDR;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        owner_q      <= winner;
        last_owner_q <= winner;
        we_q         <= sel_we;
        addr_q       <= sel_addr;
        wdata_q      <= sel_wdata;
      end
    end
  end

  assign rvalid = (state_q == WAIT) && (cnt_q == '0);

  assign bus.c_gnt    = grant && (winner == OWN_CORE);
  assign bus.l_gnt    = grant && (winner == OWN_LDR);
  assign bus.c_rvalid = rvalid && (owner_q == OWN_CORE);
  assign bus.l_rvalid = rvalid && (owner_q == OWN_LDR);
  assign bus.c_rdata  = bus.c_rvalid ? bus.mem_rdata : '0;
  assign bus.l_rdata  = bus.l_rvalid ? bus.mem_rdata : '0;

  // Address/data/we stay at their latched values between accesses.
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, latency/reset sequences and a
// randomized run against a transaction-timeline model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int RL = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vecs  = 0;
  int   errs  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  typedef struct {
    logic        rst;
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        l_req, l_we;
    logic [31:0] l_addr, l_wdata;
    logic        e_cg, e_lg, e_en, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_cv, e_lv, e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
    input logic ecg, input logic elg, input logic een, input logic ewe,
    input logic [31:0] ea, input logic [31:0] ed,
    input logic ecv, input logic elv, input logic eb);
    vec_t v;
    v.rst = rst; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.l_req = lr; v.l_we = lw; v.l_addr = la; v.l_wdata = ld;
    v.e_cg = ecg; v.e_lg = elg; v.e_en = een; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ed;
    v.e_cv = ecv; v.e_lv = elv; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, want);
    end
  endtask

  task automatic idle_in(input int which);
    if (which == 1) begin
      b1.c_req = 0; b1.c_we = 0; b1.c_addr = '0; b1.c_wdata = '0;
      b1.l_req = 0; b1.l_we = 0; b1.l_addr = '0; b1.l_wdata = '0; b1.mem_rdata = '0;
    end else begin
      b3.c_req = 0; b3.c_we = 0; b3.c_addr = '0; b3.c_wdata = '0;
      b3.l_req = 0; b3.l_we = 0; b3.l_addr = '0; b3.l_wdata = '0; b3.mem_rdata = '0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tab[22];

  // Random-run model state: one access in flight, described by its timeline.
  logic        c_pend, l_pend, c_t_we, l_t_we, m_last, win, w_we, g_c, g_l, idle;
  logic [31:0] c_t_addr, c_t_wd, l_t_addr, l_t_wd, w_addr, w_wd, rd;
  logic        iss_we, rv_own;
  logic [31:0] iss_addr, iss_wd;
  int          free_c, iss_c, rv_c;

  initial begin
    idle_in(1);
    idle_in(3);

    tab[0]  = mk(0, 1,0,32'h10,0,        0,0,0,0,                    1,0,0,0,0,0,                 0,0,0);
    tab[1]  = mk(0, 0,0,0,0,             0,0,0,0,                    0,0,1,0,32'h10,0,            0,0,1);
    tab[2]  = mk(0, 0,0,0,0,             0,0,0,0,                    0,0,0,0,0,0,                 1,0,1);
    tab[3]  = mk(0, 0,0,0,0,             0,0,0,0,                    0,0,0,0,0,0,                 0,0,0);
    tab[4]  = mk(0, 0,0,0,0,             1,1,32'h200,32'hDEADBEEF,   0,1,0,0,0,0,                 0,0,0);
    tab[5]  = mk(0, 0,0,0,0,             0,0,0,0,                    0,0,1,1,32'h200,32'hDEADBEEF,0,0,1);
    tab[6]  = mk(0, 1,1,32'h40,32'hCAFEF00D, 0,0,0,0,                1,0,0,0,0,0,                 0,0,0);
    tab[7]  = mk(0, 0,0,0,0,             0,0,0,0,                    0,0,1,1,32'h40,32'hCAFEF00D, 0,0,1);
    tab[8]  = mk(1, 1,0,32'h100,0,       1,0,32'h300,0,              0,0,0,0,0,0,                 0,0,0);
    tab[9]  = mk(0, 1,0,32'h100,0,       1,0,32'h300,0,              1,0,0,0,0,0,                 0,0,0);
    tab[10] = mk(0, 1,0,32'h100,0,       1,0,32'h300,0,              0,0,1,0,32'h100,0,           0,0,1);
    tab[11] = mk(0, 1,0,32'h100,0,       1,0,32'h300,0,              0,0,0,0,0,0,                 1,0,1);
    tab[12] = mk(0, 1,0,32'h100,0,       1,0,32'h300,0,              0,1,0,0,0,0,                 0,0,0);
    tab[13] = mk(0, 1,0,32'h100,0,       1,0,32'h300,0,              0,0,1,0,32'h300,0,           0,0,1);
    tab[14] = mk(0, 1,0,32'h100,0,       1,0,32'h300,0,              0,0,0,0,0,0,                 0,1,1);
    tab[15] = mk(0, 1,0,32'h100,0,       1,0,32'h300,0,              1,0,0,0,0,0,                 0,0,0);
    tab[16] = mk(0, 1,0,32'h100,0,       1,0,32'h300,0,              0,0,1,0,32'h100,0,           0,0,1);
    tab[17] = mk(0, 1,0,32'h100,0,       1,0,32'h300,0,              0,0,0,0,0,0,                 1,0,1);
    tab[18] = mk(0, 1,0,32'h100,0,       1,0,32'h300,0,              0,1,0,0,0,0,                 0,0,0);
    tab[19] = mk(0, 0,0,0,0,             0,0,0,0,                    0,0,1,0,32'h300,0,           0,0,1);
    tab[20] = mk(0, 0,0,0,0,             0,0,0,0,                    0,0,0,0,0,0,                 0,1,1);
    tab[21] = mk(0, 0,0,0,0,             0,0,0,0,                    0,0,0,0,0,0,                 0,0,0);

    // Reset state check, then release.
    #2;
    chk("rst_busy", {31'd0, b1.busy}, 32'd0);
    chk("rst_mem_en", {31'd0, b1.mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, b1.mem_we}, 32'd0);
    chk("rst_mem_addr", b1.mem_addr, 32'd0);
    next_cycle();

    // Directed table on the MEM_LAT=1 instance.
    for (int i = 0; i < 22; i++) begin
      reset = tab[i].rst;
      b1.c_req = tab[i].c_req; b1.c_we = tab[i].c_we;
      b1.c_addr = tab[i].c_addr; b1.c_wdata = tab[i].c_wdata;
      b1.l_req = tab[i].l_req; b1.l_we = tab[i].l_we;
      b1.l_addr = tab[i].l_addr; b1.l_wdata = tab[i].l_wdata;
      b1.mem_rdata = 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("tab%0d_c_gnt", i), {31'd0, b1.c_gnt}, {31'd0, tab[i].e_cg});
      chk($sformatf("tab%0d_l_gnt", i), {31'd0, b1.l_gnt}, {31'd0, tab[i].e_lg});
      chk($sformatf("tab%0d_mem_en", i), {31'd0, b1.mem_en}, {31'd0, tab[i].e_en});
      chk($sformatf("tab%0d_c_rvalid", i), {31'd0, b1.c_rvalid}, {31'd0, tab[i].e_cv});
      chk($sformatf("tab%0d_l_rvalid", i), {31'd0, b1.l_rvalid}, {31'd0, tab[i].e_lv});
      chk($sformatf("tab%0d_busy", i), {31'd0, b1.busy}, {31'd0, tab[i].e_busy});
      if (tab[i].e_en) begin
        chk($sformatf("tab%0d_mem_we", i), {31'd0, b1.mem_we}, {31'd0, tab[i].e_we});
        chk($sformatf("tab%0d_mem_addr", i), b1.mem_addr, tab[i].e_addr);
        chk($sformatf("tab%0d_mem_wdata", i), b1.mem_wdata, tab[i].e_wdata);
      end
      if (tab[i].e_cv) chk($sformatf("tab%0d_c_rdata", i), b1.c_rdata, 32'hC0DE_0000 + 32'(i));
      if (tab[i].e_lv) chk($sformatf("tab%0d_l_rdata", i), b1.l_rdata, 32'hC0DE_0000 + 32'(i));
      next_cycle();
    end
    reset = 1'b0;
    idle_in(1);

    // MEM_LAT=3: core read at k=0, loader write request arriving at k=2.
    for (int k = 0; k < 9; k++) begin
      b3.c_req = (k == 0); b3.c_we = 0; b3.c_addr = 32'h44;
      b3.l_req = (k >= 2 && k <= 5); b3.l_we = 1; b3.l_addr = 32'h500; b3.l_wdata = 32'h77;
      b3.mem_rdata = 32'h3000 + 32'(k);
      @(negedge clk);
      chk($sformatf("lat3_k%0d_c_gnt", k), {31'd0, b3.c_gnt}, {31'd0, k == 0});
      chk($sformatf("lat3_k%0d_l_gnt", k), {31'd0, b3.l_gnt}, {31'd0, k == 5});
      chk($sformatf("lat3_k%0d_mem_en", k), {31'd0, b3.mem_en}, {31'd0, k == 1 || k == 6});
      chk($sformatf("lat3_k%0d_c_rvalid", k), {31'd0, b3.c_rvalid}, {31'd0, k == 4});
      chk($sformatf("lat3_k%0d_l_rvalid", k), {31'd0, b3.l_rvalid}, 32'd0);
      chk($sformatf("lat3_k%0d_busy", k), {31'd0, b3.busy}, {31'd0, (k >= 1 && k <= 4) || k == 6});
      if (k == 4) chk("lat3_c_rdata", b3.c_rdata, 32'h3004);
      if (k == 6) begin
        chk("lat3_wr_addr", b3.mem_addr, 32'h500);
        chk("lat3_wr_we", {31'd0, b3.mem_we}, 32'd1);
      end
      next_cycle();
    end
    idle_in(3);

    // Reset in the middle of a MEM_LAT=3 read; the abandoned read must never return.
    for (int k = 0; k < 9; k++) begin
      reset = (k == 2);
      b3.c_req = (k == 0 || k == 3); b3.c_we = 0; b3.c_addr = (k == 0) ? 32'h60 : 32'h64;
      b3.l_req = (k == 3); b3.l_we = 0; b3.l_addr = 32'h68;
      b3.mem_rdata = 32'h4000 + 32'(k);
      @(negedge clk);
      if (k == 2) begin
        chk("rstw_busy", {31'd0, b3.busy}, 32'd0);
        chk("rstw_mem_en", {31'd0, b3.mem_en}, 32'd0);
        chk("rstw_mem_we", {31'd0, b3.mem_we}, 32'd0);
        chk("rstw_mem_addr", b3.mem_addr, 32'd0);
      end
      chk($sformatf("rstw_k%0d_c_gnt", k), {31'd0, b3.c_gnt}, {31'd0, k == 0 || k == 3});
      chk($sformatf("rstw_k%0d_l_gnt", k), {31'd0, b3.l_gnt}, 32'd0);
      chk($sformatf("rstw_k%0d_c_rvalid", k), {31'd0, b3.c_rvalid}, {31'd0, k == 7});
      if (k == 4) chk("rstw_issue_addr", b3.mem_addr, 32'h64);
      next_cycle();
    end
    reset = 1'b0;
    idle_in(3);

    // Back-to-back core stores on MEM_LAT=1, loader idle.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      b1.c_req = 1; b1.c_we = 1;
      b1.c_addr = 32'h1000 + 32'(4 * ((k + 1) / 2));
      b1.c_wdata = 32'hA000 + 32'((k + 1) / 2);
      @(negedge clk);
      chk($sformatf("st_k%0d_c_gnt", k), {31'd0, b1.c_gnt}, {31'd0, (k % 2) == 0});
      chk($sformatf("st_k%0d_mem_en", k), {31'd0, b1.mem_en}, {31'd0, (k % 2) == 1});
      if ((k % 2) == 1) begin
        chk($sformatf("st_k%0d_addr", k), b1.mem_addr, 32'h1000 + 32'(4 * ((k - 1) / 2)));
        chk($sformatf("st_k%0d_we", k), {31'd0, b1.mem_we}, 32'd1);
      end
      chk($sformatf("st_k%0d_c_rvalid", k), {31'd0, b1.c_rvalid}, 32'd0);
      next_cycle();
    end
    idle_in(1);

    // Randomized run against the timeline model.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    free_c = 0; iss_c = -1; rv_c = -1; m_last = 1'b1;
    c_pend = 0; l_pend = 0;
    c_t_we = 0; l_t_we = 0; c_t_addr = 0; l_t_addr = 0; c_t_wd = 0; l_t_wd = 0;
    iss_we = 0; iss_addr = 0; iss_wd = 0; rv_own = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!c_pend && $urandom_range(0, 9) < 6) begin
        c_pend = 1; c_t_we = 1'($urandom_range(0, 1)); c_t_addr = $urandom; c_t_wd = $urandom;
      end
      if (!l_pend && $urandom_range(0, 9) < 6) begin
        l_pend = 1; l_t_we = 1'($urandom_range(0, 1)); l_t_addr = $urandom; l_t_wd = $urandom;
      end
      b1.c_req = c_pend; b1.c_we = c_t_we; b1.c_addr = c_t_addr; b1.c_wdata = c_t_wd;
      b1.l_req = l_pend; b1.l_we = l_t_we; b1.l_addr = l_t_addr; b1.l_wdata = l_t_wd;
      rd = $urandom;
      b1.mem_rdata = rd;
      @(negedge clk);
      idle = (cyc >= free_c);
      g_c = 0; g_l = 0; win = 0;
      if (idle && (c_pend || l_pend)) begin
        win = (c_pend && l_pend) ? !m_last : l_pend;
        g_c = !win; g_l = win;
      end
      chk("rnd_c_gnt", {31'd0, b1.c_gnt}, {31'd0, g_c});
      chk("rnd_l_gnt", {31'd0, b1.l_gnt}, {31'd0, g_l});
      chk("rnd_busy", {31'd0, b1.busy}, {31'd0, !idle});
      chk("rnd_mem_en", {31'd0, b1.mem_en}, {31'd0, cyc == iss_c});
      if (cyc == iss_c) begin
        chk("rnd_mem_we", {31'd0, b1.mem_we}, {31'd0, iss_we});
        chk("rnd_mem_addr", b1.mem_addr, iss_addr);
        chk("rnd_mem_wdata", b1.mem_wdata, iss_wd);
      end
      chk("rnd_c_rvalid", {31'd0, b1.c_rvalid}, {31'd0, cyc == rv_c && !rv_own});
      chk("rnd_l_rvalid", {31'd0, b1.l_rvalid}, {31'd0, cyc == rv_c && rv_own});
      if (cyc == rv_c) chk("rnd_rdata", rv_own ? b1.l_rdata : b1.c_rdata, rd);
      if (g_c || g_l) begin
        w_we   = win ? l_t_we : c_t_we;
        w_addr = win ? l_t_addr : c_t_addr;
        w_wd   = win ? l_t_wd : c_t_wd;
        m_last = win;
        free_c = cyc + (w_we ? 2 : 2 + RL);
        iss_c  = cyc + 1;
        iss_we = w_we; iss_addr = w_addr; iss_wd = w_wd;
        rv_c   = w_we ? -1 : cyc + 1 + RL;
        rv_own = win;
        if (win) l_pend = 0;
        else     c_pend = 0;
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the multicycle core's memory interface and the UART program loader.
- Sequences each access through fixed phases: grant, issue, read-latency wait.
- Round-robin arbitration on contention.
- The core FSM treats "request without gnt" and "read without rvalid" as stall conditions, so the arbiter sets its memory timing.

Parameters:
ADDR_W, 32, address width of memory port and requesters
DATA_W, 32, data width
MEM_LAT, 1, synchronous read latency in cycles from mem_en cycle to mem_rdata valid (legal 1..4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
c_req  in  1  core request; held with c_we/c_addr/c_wdata until c_gnt
c_we  in  1  core write enable (1 = store)
c_addr  in  ADDR_W  core address
c_wdata  in  DATA_W  core store data
c_gnt  out  1  one-cycle accept pulse to core
c_rvalid  out  1  one-cycle core read-data valid
c_rdata  out  DATA_W  core read data, meaningful only when c_rvalid
l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as core
l_gnt, l_rvalid  out  1  loader accept / read-valid pulses
l_rdata  out  DATA_W  loader read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT.
- IDLE, no requests: all outputs low, stay IDLE.
- IDLE, any request:
  - Winner: the sole requester; if both, the one not served last (last_owner pointer).
  - Winner's gnt is asserted combinationally in the same cycle.
  - At the clock edge: latch owner, we, addr, wdata; update last_owner; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata from the latched values.
  - Write: next state IDLE; no rvalid.
  - Read: load counter = MEM_LAT-1; go to WAIT.
- WAIT:
  - Counter nonzero: decrement.
  - Counter zero: pulse owner's rvalid; owner's rdata = mem_rdata (combinational pass-through); next state IDLE.
- Read latency, gnt cycle T: mem_en at T+1, rvalid at T+1+MEM_LAT; next grant possible at T+2+MEM_LAT.
- Write occupancy: 2 cycles (T, T+1); next grant at T+2.
- Requests in ISSUE/WAIT are ignored (no gnt). Requesters hold until granted; the arbiter never drops or queues a request.
- Non-owner's gnt/rvalid are always 0. At most one gnt per cycle.
- mem_en=0 outside ISSUE. mem_addr/mem_wdata/mem_we hold their latched values when mem_en=0.
- Requester dropping req after gnt has no effect. Dropping req before gnt (illegal) simply loses arbitration.
- Reset, asynchronous, any state:
  - state=IDLE, counter=0, all gnt/rvalid/mem_en/mem_we/busy=0.
  - latched addr/wdata=0, last_owner=LOADER, so the core wins the first tie.
  - An in-flight access is abandoned; no rvalid is issued after reset.
- Reset deasserted with requests pending: grant in the first cycle after deassertion, per the rules above.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT}.
  - owner_t enum {OWN_CORE=0, OWN_LDR=1}.
  - localparam LAT_W = $clog2(MEM_LAT+1), computed in the module.
- Sub-module rr_pick2: 2-way round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: winner, any.
  - Purely combinational.
- The FSM, latches and counter stay in mem_port_arbiter.

Test Plan:
- Core read alone (MEM_LAT=1): c_req=1, c_we=0, c_addr=0x10 at T -> c_gnt at T, mem_en=1 with mem_addr=0x10 at T+1, c_rvalid=1 with c_rdata=mem_rdata at T+2, busy low at T+3.
- Loader write alone: l_we=1, l_addr=0x200, l_wdata=0xDEADBEEF -> l_gnt at T, mem_en=mem_we=1 with those values at T+1, no l_rvalid, next grant possible at T+2.
- Contention after reset: both req held continuously, reads -> grants alternate core, loader, core, loader; exactly one gnt per cycle; each rvalid goes only to its owner.
- MEM_LAT=3 read: gnt at T -> rvalid at T+4; a loader req arriving at T+2 is granted at T+5.
- Reset mid-WAIT: assert reset during WAIT of a core read -> all outputs 0 immediately, no c_rvalid ever; after release with both requesting, core is granted first.
- Back-to-back core stores with l_req idle -> gnt every 2 cycles, mem_en duty 50%, addresses in order.
